// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI byte sequencer.
// No logic; state encoding, default parameters and a width helper.
// Backpressure: n/a.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int DEF_TX_DEPTH       = 8;
    localparam int DEF_RX_DEPTH       = 8;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Bits needed to index 'value' entries; never less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with extra-MSB pointers.
// Latency: write visible at rd_data one cycle later; read is combinational.
// Backpressure: write accepted when not full, or when full with a same-cycle read.
module sync_fifo
    import spi_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Streams TX FIFO bytes into a byte SPI master and collects replies into an RX FIFO.
// Latency: queued byte with idle master drives m_w_en low two cycles later.
// Backpressure: tx_ready tracks TX space; a byte is only issued once RX space is reserved.
module spi_byte_sequencer
    import spi_seq_pkg::*;
#(
    parameter int TX_DEPTH       = DEF_TX_DEPTH,
    parameter int RX_DEPTH       = DEF_RX_DEPTH,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  m_data_in,
    output logic        m_w_en,
    input  logic [7:0]  m_data_out,
    input  logic        m_spi_done,
    input  logic        m_spi_idle,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] byte_count
);

    localparam int WD_W  = clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = clog2(GAP_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    state_t           state_nxt;
    logic             tx_full;
    logic             tx_empty;
    logic [7:0]       tx_head;
    logic             rx_full;
    logic             rx_empty;
    logic             tx_pop;
    logic             rx_push;
    logic             rx_pop;
    logic             issue_ok;
    logic             wd_expire;
    logic             gap_done;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;

    assign rx_valid  = ~rx_empty;
    assign rx_pop    = ~rx_empty & rx_ready;
    // A same-cycle RX pop frees the slot the issued byte will land in.
    assign issue_ok  = ~tx_empty & (~rx_full | rx_pop) & m_spi_idle;
    assign wd_expire = (wd_cnt == WD_LAST);
    assign gap_done  = (gap_cnt == GAP_LAST);
    assign tx_ready  = ~tx_full | tx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .full    (tx_full),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .empty   (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (m_data_out),
        .full    (rx_full),
        .rd_en   (rx_pop),
        .rd_data (rx_data),
        .empty   (rx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue_ok) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (m_spi_done || wd_expire) state_nxt = S_GAP;
            S_GAP:   if (gap_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        m_w_en  = 1'b1;
        busy    = (state != S_IDLE);
        case (state)
            S_IDLE:  tx_pop  = issue_ok;
            S_START: m_w_en  = 1'b0;
            S_WAIT:  rx_push = m_spi_done;
            default: ;
        endcase
    end

    // Done wins over an expiring watchdog in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_in   <= '0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
            byte_count  <= '0;
        end else begin
            if (tx_pop) m_data_in <= tx_head;
            if (state == S_START)     wd_cnt <= '0;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + WD_W'(1);
            gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (state == S_WAIT && !m_spi_done && wd_expire) timeout_err <= 1'b1;
            if (rx_push) byte_count <= byte_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a behavioural loopback SPI master.
// Master answers four cycles after each start unless told to hang or stay busy.
module tb_spi_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  m_data_in;
    logic        m_w_en;
    logic [7:0]  m_data_out;
    logic        m_spi_done;
    logic        m_spi_idle;
    logic        busy;
    logic        timeout_err;
    logic [15:0] byte_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       hang = 1'b0;
    logic       hold = 1'b0;
    logic       model_idle;
    int         busy_cnt;
    logic [7:0] mosi_q;
    int         start_cnt;
    int         last_done;
    bit         have_done;
    int         min_gap;
    logic [7:0] start_log[$];
    logic [7:0] rx_log[$];

    spi_byte_sequencer #(
        .TX_DEPTH(8), .RX_DEPTH(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .m_data_in(m_data_in), .m_w_en(m_w_en), .m_data_out(m_data_out),
        .m_spi_done(m_spi_done), .m_spi_idle(m_spi_idle),
        .busy(busy), .timeout_err(timeout_err), .byte_count(byte_count)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    assign m_spi_idle = model_idle & ~hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_idle <= 1'b1;
            m_spi_done <= 1'b0;
            m_data_out <= '0;
            busy_cnt  = 0;
            start_cnt = 0;
            have_done = 0;
            min_gap   = 999;
            start_log.delete();
        end else begin
            m_spi_done <= 1'b0;
            if (m_spi_done) begin
                last_done = cyc;
                have_done = 1;
            end
            if (!m_w_en) begin
                start_cnt++;
                start_log.push_back(m_data_in);
                if (have_done && (cyc - last_done) < min_gap) min_gap = cyc - last_done;
                mosi_q = m_data_in;
                if (!hang) begin
                    busy_cnt = 4;
                    model_idle <= 1'b0;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    m_spi_done <= 1'b1;
                    m_data_out <= mosi_q;
                    model_idle <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rx_log.delete();
        else if (rx_valid && rx_ready) rx_log.push_back(rx_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_wait(input logic [7:0] b);
        int n;
        n = 0;
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("push_wait_to", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_count(input int n);
        for (int i = 0; i < 3000 && byte_count != 16'(n); i++) @(negedge clk);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 200 && m_w_en; i++) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int bad;

        #1;
        chk("rst_w_en",   m_w_en, 1);
        chk("rst_data",   m_data_in, 0);
        chk("rst_txrdy",  tx_ready, 1);
        chk("rst_rxvld",  rx_valid, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_tmo",    timeout_err, 0);
        chk("rst_count",  byte_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single byte: start pulse two cycles after the write, loopback reply.
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t1_lat1", m_w_en, 1);
        @(negedge clk);
        chk("t1_start", m_w_en, 0);
        chk("t1_mdata", m_data_in, 8'hA5);
        @(negedge clk);
        chk("t1_one_pulse", m_w_en, 1);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 50 && !rx_valid; i++) @(negedge clk);
        chk("t1_rxvld", rx_valid, 1);
        chk("t1_rxdat", rx_data, 8'hA5);
        chk("t1_count", byte_count, 1);
        chk("t1_starts", start_cnt, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("t1_popped", rx_valid, 0);

        // Burst of eight with a two-cycle gap.
        do_reset();
        rx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_wait(8'(i));
        wait_count(8);
        repeat (3) @(negedge clk);
        chk("t2_count", byte_count, 8);
        chk("t2_nstart", start_log.size(), 8);
        chk("t2_nrx", rx_log.size(), 8);
        bad = 0;
        for (int i = 0; i < start_log.size(); i++) if (start_log[i] != 8'(i + 1)) bad++;
        chk("t2_start_order", bad, 0);
        bad = 0;
        for (int i = 0; i < rx_log.size(); i++) if (rx_log[i] != 8'(i + 1)) bad++;
        chk("t2_rx_order", bad, 0);
        // done edge -> 2 gap cycles -> idle -> start: four cycles apart.
        chk("t2_min_gap", min_gap, 4);

        // RX backpressure: eight fill the RX FIFO, two stay queued in TX.
        do_reset();
        rx_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_wait(8'h21 + 8'(i));
        wait_count(8);
        repeat (40) @(negedge clk);
        chk("t3_count8", byte_count, 8);
        chk("t3_starts8", start_cnt, 8);
        chk("t3_idle", busy, 0);
        chk("t3_txrdy", tx_ready, 1);
        chk("t3_rxvld", rx_valid, 1);
        rx_ready = 1'b1;
        wait_count(10);
        repeat (3) @(negedge clk);
        chk("t3_count10", byte_count, 10);
        chk("t3_nrx", rx_log.size(), 10);
        bad = 0;
        for (int i = 0; i < rx_log.size(); i++) if (rx_log[i] != 8'h21 + 8'(i)) bad++;
        chk("t3_rx_order", bad, 0);

        // Watchdog: master never answers.
        do_reset();
        hang = 1'b1;
        push_wait(8'h33);
        wait_start();
        chk("t4_start", m_w_en, 0);
        repeat (16) @(negedge clk);
        chk("t4_tmo_pre", timeout_err, 0);
        @(negedge clk);
        chk("t4_tmo", timeout_err, 1);
        chk("t4_gap_busy", busy, 1);
        repeat (5) @(negedge clk);
        chk("t4_count", byte_count, 0);
        chk("t4_nrx", rx_log.size(), 0);
        hang = 1'b0;
        push_wait(8'h44);
        wait_count(1);
        repeat (3) @(negedge clk);
        chk("t4_next_count", byte_count, 1);
        chk("t4_next_nrx", rx_log.size(), 1);
        if (rx_log.size() > 0) chk("t4_next_rx", rx_log[0], 8'h44);
        chk("t4_sticky", timeout_err, 1);
        chk("t4_starts", start_cnt, 2);

        // Reset while waiting on the master with bytes queued.
        push_wait(8'h51);
        push_wait(8'h52);
        push_wait(8'h53);
        wait_start();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_w_en", m_w_en, 1);
        chk("t5_data", m_data_in, 0);
        chk("t5_txrdy", tx_ready, 1);
        chk("t5_rxvld", rx_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_tmo", timeout_err, 0);
        chk("t5_count", byte_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("t5_no_start", start_cnt, 0);
        push_wait(8'h77);
        wait_start();
        chk("t5_new_start", m_w_en, 0);
        chk("t5_new_data", m_data_in, 8'h77);

        // TX full while the master is held busy.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) push_wait(8'h60 + 8'(i));
        chk("t6_full", tx_ready, 0);
        tx_data = 8'hEE; tx_valid = 1'b1;
        #1;
        chk("t6_full_wr", tx_ready, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t6_held", busy, 0);
        hold = 1'b0;
        wait_count(8);
        repeat (40) @(negedge clk);
        chk("t6_count", byte_count, 8);
        chk("t6_starts", start_cnt, 8);
        chk("t6_nrx", rx_log.size(), 8);
        bad = 0;
        for (int i = 0; i < rx_log.size(); i++) if (rx_log[i] != 8'h60 + 8'(i)) bad++;
        chk("t6_rx_order", bad, 0);
        chk("t6_txrdy", tx_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
